// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//
// Purpose:
//   Resolves branches in EX against the BTB prediction made at fetch time.
//   A 2-entry shadow pipeline (ID, EX) carries the fetch-time prediction
//   {valid, PC, hit, predicted target} alongside the real pipeline. When the
//   EX instruction is a branch, the prediction is compared with the actual
//   outcome. A mispredict triggers a one-cycle RECOVER state that flushes the
//   front end and redirects fetch. A taken branch that the BTB missed, or
//   whose predicted target was wrong, produces a one-cycle BTB write.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   PC_IF, Hit_IF,
//   Target_IF,
//   Valid_IF          - fetch-stage PC, BTB hit/target, slot-valid
//   Stall             - pipeline hold for IF/ID/EX
//   Is_Branch_Ex,
//   Taken_Ex, PC_ALU  - EX-stage branch flag, actual outcome, actual target
//   Br_Dectected      - BTB write enable (registered, one-cycle pulse)
//   PC_Ex             - EX-slot PC (combinational), BTB write index/tag
//   PC_ALU_Out        - BTB write data (registered)
//   Flush             - squash IF/ID and ID/EX (high during RECOVER)
//   Redirect_PC       - corrected fetch PC, valid while Flush=1
//   Br_Count,
//   Mispred_Count     - saturating resolved-branch / mispredict counters
// ---------------------------------------------------------------------------
module branch_resolve #(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_IF,
    input  logic                         Hit_IF,
    input  logic [WIDTH_DATA_LENGTH-1:0] Target_IF,
    input  logic                         Valid_IF,
    input  logic                         Stall,
    input  logic                         Is_Branch_Ex,
    input  logic                         Taken_Ex,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
    output logic                         Br_Dectected,
    output logic [WIDTH_DATA_LENGTH-1:0] PC_Ex,
    output logic [WIDTH_DATA_LENGTH-1:0] PC_ALU_Out,
    output logic                         Flush,
    output logic [WIDTH_DATA_LENGTH-1:0] Redirect_PC,
    output logic [CNT_WIDTH-1:0]         Br_Count,
    output logic [CNT_WIDTH-1:0]         Mispred_Count
);

    localparam int W = WIDTH_DATA_LENGTH;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] pc;
        logic         hit;
        logic [W-1:0] tgt;
    } slot_t;

    state_t               state_q, state_d;
    slot_t                id_q, id_d;
    slot_t                ex_q, ex_d;
    logic                 br_det_q, br_det_d;
    logic [W-1:0]         alu_out_q, alu_out_d;
    logic [W-1:0]         redirect_q, redirect_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

    logic resolve;
    logic update;
    logic mispred;

    always_comb begin
        // NOTE: every variable gets a hold/idle default first so no path
        // through this block can leave one unassigned and infer a latch.
        state_d    = state_q;
        id_d       = id_q;
        ex_d       = ex_q;
        br_det_d   = 1'b0;
        alu_out_d  = alu_out_q;
        redirect_d = redirect_q;
        br_cnt_d   = br_cnt_q;
        mis_cnt_d  = mis_cnt_q;

        // During RECOVER the EX instruction is wrong-path, so it never resolves.
        resolve = ex_q.valid && Is_Branch_Ex && !Stall && (state_q == IDLE);
        // BTB needs (re)writing when a taken branch missed or hit with a stale target.
        update  = Taken_Ex && (!ex_q.hit || (ex_q.tgt != PC_ALU));
        mispred = update || (!Taken_Ex && ex_q.hit);

        if (resolve) begin
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
            if (mispred && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
            if (update) begin
                br_det_d  = 1'b1;
                alu_out_d = PC_ALU;
            end
            if (mispred) redirect_d = Taken_Ex ? PC_ALU : (ex_q.pc + W'(4));
        end

        case (state_q)
            IDLE:    if (resolve && mispred) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Flush wins over Stall: the squash happens even if the pipe is held.
        if (state_q == RECOVER) begin
            id_d.valid = 1'b0;
            ex_d.valid = 1'b0;
        end else if (!Stall) begin
            id_d = '{valid: Valid_IF, pc: PC_IF, hit: Hit_IF, tgt: Target_IF};
            ex_d = id_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            ex_q       <= '0;
            br_det_q   <= 1'b0;
            alu_out_q  <= '0;
            redirect_q <= '0;
            br_cnt_q   <= '0;
            mis_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            ex_q       <= ex_d;
            br_det_q   <= br_det_d;
            alu_out_q  <= alu_out_d;
            redirect_q <= redirect_d;
            br_cnt_q   <= br_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    assign PC_Ex         = ex_q.pc;
    assign Flush         = (state_q == RECOVER);
    assign Redirect_PC   = redirect_q;
    assign Br_Dectected  = br_det_q;
    assign PC_ALU_Out    = alu_out_q;
    assign Br_Count      = br_cnt_q;
    assign Mispred_Count = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
//
// Self-checking bench for branch_resolve: a table of single-branch scenarios,
// hand-written multi-cycle sequences (back-to-back, stall, reset in RECOVER,
// counter saturation), then randomized traffic against a behavioural model.
// CNT_WIDTH is reduced so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_branch_resolve;

    localparam int W       = 32;
    localparam int CW      = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  PC_IF, Target_IF, PC_ALU;
    logic          Hit_IF, Valid_IF, Stall, Is_Branch_Ex, Taken_Ex;
    logic          Br_Dectected, Flush;
    logic [W-1:0]  PC_Ex, PC_ALU_Out, Redirect_PC;
    logic [CW-1:0] Br_Count, Mispred_Count;

    always #5 clk = ~clk;

    branch_resolve #(.WIDTH_DATA_LENGTH(W), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_IF         (PC_IF),
        .Hit_IF        (Hit_IF),
        .Target_IF     (Target_IF),
        .Valid_IF      (Valid_IF),
        .Stall         (Stall),
        .Is_Branch_Ex  (Is_Branch_Ex),
        .Taken_Ex      (Taken_Ex),
        .PC_ALU        (PC_ALU),
        .Br_Dectected  (Br_Dectected),
        .PC_Ex         (PC_Ex),
        .PC_ALU_Out    (PC_ALU_Out),
        .Flush         (Flush),
        .Redirect_PC   (Redirect_PC),
        .Br_Count      (Br_Count),
        .Mispred_Count (Mispred_Count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; PC_IF = '0; Hit_IF = 1'b0; Target_IF = '0; Valid_IF = 1'b0;
        Stall = 1'b0; Is_Branch_Ex = 1'b0; Taken_Ex = 1'b0; PC_ALU = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Fetch one instruction, then a bubble, so it sits in EX afterwards.
    task automatic load_ex(input logic [W-1:0] pc, input logic hit, input logic [W-1:0] tgt);
        Valid_IF = 1'b1; PC_IF = pc; Hit_IF = hit; Target_IF = tgt;
        step();
        Valid_IF = 1'b0; PC_IF = '0; Hit_IF = 1'b0; Target_IF = '0;
        step();
    endtask

    task automatic resolve_ex(input logic taken, input logic [W-1:0] alu);
        Is_Branch_Ex = 1'b1; Taken_Ex = taken; PC_ALU = alu;
        step();
        Is_Branch_Ex = 1'b0; Taken_Ex = 1'b0; PC_ALU = '0;
    endtask

    typedef struct {
        logic [W-1:0] pc;
        logic         hit;
        logic [W-1:0] tgt;
        logic         taken;
        logic [W-1:0] alu;
        logic         e_flush;
        logic [W-1:0] e_redirect;
        logic         e_det;
        logic [W-1:0] e_alu_out;
        int           e_mis;
    } vec_t;

    vec_t vecs[6];

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit           v;
        logic [W-1:0] pc;
        bit           hit;
        logic [W-1:0] tgt;
    } mslot_t;

    mslot_t       m_pipe[2];   // [0] = ID, [1] = EX
    bit           m_flush;
    bit           m_det;
    int           m_br, m_mis;
    logic [W-1:0] m_alu_out, m_redir;

    task automatic model_reset();
        m_pipe[0] = '{0, '0, 0, '0};
        m_pipe[1] = '{0, '0, 0, '0};
        m_flush = 0; m_det = 0; m_br = 0; m_mis = 0;
        m_alu_out = '0; m_redir = '0;
    endtask

    task automatic model_edge();
        bit res, wrong_tgt, mis;
        if (rst) begin
            model_reset();
            return;
        end
        res       = !m_flush && m_pipe[1].v && Is_Branch_Ex && !Stall;
        wrong_tgt = Taken_Ex && (!m_pipe[1].hit || m_pipe[1].tgt != PC_ALU);
        mis       = wrong_tgt || (!Taken_Ex && m_pipe[1].hit);
        m_det     = res && wrong_tgt;
        if (m_det) m_alu_out = PC_ALU;
        if (res) m_br = (m_br < CNT_MAX) ? m_br + 1 : CNT_MAX;
        if (res && mis) begin
            m_mis   = (m_mis < CNT_MAX) ? m_mis + 1 : CNT_MAX;
            m_redir = Taken_Ex ? PC_ALU : m_pipe[1].pc + 32'd4;
        end
        if (m_flush) begin
            m_pipe[0].v = 0;
            m_pipe[1].v = 0;
        end else if (!Stall) begin
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = '{Valid_IF, PC_IF, Hit_IF, Target_IF};
        end
        m_flush = res && mis;
    endtask

    task automatic rand_cycle();
        rst          = ($urandom_range(0, 63) == 0);
        Valid_IF     = ($urandom_range(0, 9) < 8);
        PC_IF        = 32'($urandom_range(0, 255)) << 2;
        Hit_IF       = 1'($urandom_range(0, 1));
        Target_IF    = 32'($urandom_range(1, 3)) << 8;
        Stall        = ($urandom_range(0, 4) == 0);
        Is_Branch_Ex = 1'($urandom_range(0, 1));
        Taken_Ex     = 1'($urandom_range(0, 1));
        PC_ALU       = 32'($urandom_range(1, 3)) << 8;
        if (m_pipe[1].v) check("rnd_pc_ex", PC_Ex, m_pipe[1].pc);
        model_edge();
        step();
        check("rnd_flush", Flush, m_flush);
        if (m_flush) check("rnd_redirect", Redirect_PC, m_redir);
        check("rnd_det", Br_Dectected, m_det);
        check("rnd_alu_out", PC_ALU_Out, m_alu_out);
        check("rnd_br_cnt", Br_Count, m_br);
        check("rnd_mis_cnt", Mispred_Count, m_mis);
    endtask

    initial begin
        //         pc            hit  tgt        tk   alu           flush redirect      det  alu_out   mis
        vecs[0] = '{32'h40,      1'b0, 32'h0,    1'b1, 32'h100,    1'b1, 32'h100,     1'b1, 32'h100, 1}; // cold miss
        vecs[1] = '{32'h40,      1'b1, 32'h100,  1'b1, 32'h100,    1'b0, 32'h0,       1'b0, 32'h0,   0}; // correct hit
        vecs[2] = '{32'h40,      1'b1, 32'h100,  1'b0, 32'h200,    1'b1, 32'h44,      1'b0, 32'h0,   1}; // false taken
        vecs[3] = '{32'h80,      1'b1, 32'h100,  1'b1, 32'h300,    1'b1, 32'h300,     1'b1, 32'h300, 1}; // wrong target
        vecs[4] = '{32'h80,      1'b0, 32'h0,    1'b0, 32'h300,    1'b0, 32'h0,       1'b0, 32'h0,   0}; // correct not-taken
        vecs[5] = '{32'hFFFFFFFC, 1'b1, 32'h10,  1'b0, 32'h10,     1'b1, 32'h0,       1'b0, 32'h0,   1}; // PC+4 wraps

        do_reset();
        check("rst_flush", Flush, 0);
        check("rst_det", Br_Dectected, 0);
        check("rst_br_cnt", Br_Count, 0);
        check("rst_mis_cnt", Mispred_Count, 0);
        check("rst_redirect", Redirect_PC, 0);
        check("rst_alu_out", PC_ALU_Out, 0);

        // ---------- table-driven single-branch scenarios ----------
        foreach (vecs[i]) begin
            do_reset();
            load_ex(vecs[i].pc, vecs[i].hit, vecs[i].tgt);
            check($sformatf("v%0d_pc_ex", i), PC_Ex, vecs[i].pc);
            resolve_ex(vecs[i].taken, vecs[i].alu);
            check($sformatf("v%0d_flush", i), Flush, vecs[i].e_flush);
            check($sformatf("v%0d_redirect", i), Redirect_PC, vecs[i].e_redirect);
            check($sformatf("v%0d_det", i), Br_Dectected, vecs[i].e_det);
            check($sformatf("v%0d_alu_out", i), PC_ALU_Out, vecs[i].e_alu_out);
            check($sformatf("v%0d_br_cnt", i), Br_Count, 1);
            check($sformatf("v%0d_mis_cnt", i), Mispred_Count, vecs[i].e_mis);
            step();
            check($sformatf("v%0d_det_pulse", i), Br_Dectected, 0);
            check($sformatf("v%0d_flush_end", i), Flush, 0);
        end

        // ---------- back-to-back branches, first mispredicted ----------
        do_reset();
        Valid_IF = 1'b1; PC_IF = 32'h40; Hit_IF = 1'b0; Target_IF = '0;
        step();
        PC_IF = 32'h44;
        step();
        PC_IF = 32'h48;
        check("b2b_pc_ex", PC_Ex, 32'h40);
        Is_Branch_Ex = 1'b1; Taken_Ex = 1'b1; PC_ALU = 32'h100;
        step();                           // resolves 0x40; 0x44 moves into EX
        check("b2b_flush", Flush, 1);
        check("b2b_redirect", Redirect_PC, 32'h100);
        step();                           // RECOVER: 0x44 branch ignored
        Valid_IF = 1'b0;
        check("b2b_flush_end", Flush, 0);
        check("b2b_br_cnt", Br_Count, 1);
        check("b2b_mis_cnt", Mispred_Count, 1);
        step();
        step();                           // Is_Branch_Ex still high, slots must be empty
        check("b2b_no_res_flush", Flush, 0);
        check("b2b_no_res_br", Br_Count, 1);
        check("b2b_no_res_det", Br_Dectected, 0);
        idle_inputs();

        // ---------- stall holds a branch in EX; stall during RECOVER ----------
        do_reset();
        load_ex(32'h40, 1'b0, 32'h0);
        Stall = 1'b1; Is_Branch_Ex = 1'b1; Taken_Ex = 1'b1; PC_ALU = 32'h100;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_flush", Flush, 0);
            check("stall_br_cnt", Br_Count, 0);
            check("stall_pc_ex", PC_Ex, 32'h40);
        end
        Stall = 1'b0;
        step();
        check("stall_res_flush", Flush, 1);
        check("stall_res_br", Br_Count, 1);
        Stall = 1'b1;
        step();                           // RECOVER with Stall=1 still ends
        check("stall_rec_flush", Flush, 0);
        check("stall_rec_br", Br_Count, 1);
        Stall = 1'b0;
        step();
        check("stall_after_br", Br_Count, 1);
        idle_inputs();

        // ---------- reset during RECOVER ----------
        do_reset();
        load_ex(32'h40, 1'b0, 32'h0);
        resolve_ex(1'b1, 32'h100);
        check("rstrec_flush_pre", Flush, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstrec_flush", Flush, 0);
        check("rstrec_br_cnt", Br_Count, 0);
        check("rstrec_mis_cnt", Mispred_Count, 0);
        check("rstrec_det", Br_Dectected, 0);
        check("rstrec_redirect", Redirect_PC, 0);
        check("rstrec_alu_out", PC_ALU_Out, 0);

        // ---------- counter saturation ----------
        do_reset();
        for (int k = 0; k < CNT_MAX + 3; k++) begin
            load_ex(32'h40, 1'b0, 32'h0);
            resolve_ex(1'b1, 32'h100);
            step();
        end
        check("sat_mis_cnt", Mispred_Count, CNT_MAX);
        check("sat_br_cnt", Br_Count, CNT_MAX);
        load_ex(32'h40, 1'b1, 32'h100);
        resolve_ex(1'b1, 32'h100);
        check("sat_hold_mis", Mispred_Count, CNT_MAX);
        check("sat_hold_br", Br_Count, CNT_MAX);

        // ---------- randomized traffic against the model ----------
        do_reset();
        model_reset();
        for (int k = 0; k < 3000; k++) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL have parameter WIDTH_DATA_LENGTH, default 32, meaning PC and target width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning statistics counter width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port PC_IF, input, 32, meaning the fetch-stage PC.
REQ-006 The block SHALL have port Hit_IF, input, 1, meaning the BTB hit for PC_IF.
REQ-007 The block SHALL have port Target_IF, input, 32, meaning the BTB predicted target for PC_IF.
REQ-008 The block SHALL have port Valid_IF, input, 1, meaning the fetch slot holds a real instruction.
REQ-009 The block SHALL have port Stall, input, 1, meaning the pipeline holds IF, ID and EX.
REQ-010 The block SHALL have port Is_Branch_Ex, input, 1, meaning the EX instruction is a branch or jump.
REQ-011 The block SHALL have port Taken_Ex, input, 1, meaning the actual branch outcome in EX.
REQ-012 The block SHALL have port PC_ALU, input, 32, meaning the actual target computed in EX.
REQ-013 The block SHALL have port Br_Dectected, output, 1, meaning the BTB write enable.
REQ-014 The block SHALL have port PC_Ex, output, 32, meaning the EX-slot PC, used as the BTB write index/tag.
REQ-015 The block SHALL have port PC_ALU_Out, output, 32, meaning the BTB write data.
REQ-016 The block SHALL have port Flush, output, 1, meaning squash of IF/ID and ID/EX.
REQ-017 The block SHALL have port Redirect_PC, output, 32, meaning the corrected fetch PC, valid when Flush=1.
REQ-018 The block SHALL have ports Br_Count and Mispred_Count, output, CNT_WIDTH, meaning resolved-branch and misprediction counters.

Function
REQ-019 The block SHALL keep a 2-slot shadow pipeline, ID and EX, each holding {valid, PC, hit, predicted target}.
REQ-020 Slot advance (Stall=0, Flush=0): ID <= {Valid_IF, PC_IF, Hit_IF, Target_IF}; EX <= ID.
REQ-021 When Stall=1 and Flush=0, both slots SHALL hold their contents.
REQ-022 The EX slot SHALL resolve only when EX.valid=1, Is_Branch_Ex=1, Stall=0 and state=IDLE.
REQ-023 Mispredict SHALL be (Taken_Ex & (~EX.hit | EX.target != PC_ALU)) | (~Taken_Ex & EX.hit).
REQ-024 Update SHALL be Taken_Ex & (~EX.hit | EX.target != PC_ALU).
REQ-025 PC_Ex SHALL be EX.PC combinationally; Br_Dectected and PC_ALU_Out SHALL be registered, asserting one cycle after resolution for exactly one cycle.
REQ-026 The FSM SHALL have states IDLE and RECOVER: a resolution with mispredict moves IDLE->RECOVER; RECOVER->IDLE after one cycle unconditionally.
REQ-027 In RECOVER, Flush=1 and Redirect_PC = PC_ALU if taken, else EX.PC+4 (mod 2^32), both registered at resolution.
REQ-028 In RECOVER, both slots SHALL be invalidated on the next edge, and Is_Branch_Ex SHALL be ignored (wrong-path instruction).
REQ-029 Flush SHALL take priority over Stall; a RECOVER cycle with Stall=1 still squashes and returns to IDLE.
REQ-030 Br_Count SHALL increment on each resolution; Mispred_Count SHALL increment on each mispredicting resolution; both SHALL saturate at all-ones.
REQ-031 A correctly predicted branch SHALL cause no Flush; Br_Dectected SHALL assert only if Update=1.

Reset
REQ-032 On rst=1 at a rising edge, the state SHALL go to IDLE, slot valids to 0, and Flush, Br_Dectected, both counters, Redirect_PC and PC_ALU_Out to 0; rst SHALL override all other inputs, including mid-RECOVER.

Verification
REQ-033 Cold miss: EX PC=0x40, hit=0, Taken=1, PC_ALU=0x100 -> next cycle Br_Dectected=1, PC_ALU_Out=0x100, Flush=1, Redirect_PC=0x100, Mispred_Count=1.
REQ-034 Correct hit: hit=1, target=0x100, Taken=1, PC_ALU=0x100 -> Flush=0, Br_Dectected=0, Br_Count+1.
REQ-035 False taken: hit=1, Taken=0, PC=0x40 -> Flush=1, Redirect_PC=0x44, Br_Dectected=0.
REQ-036 Back-to-back branches with the first mispredicted -> the second (wrong-path) is ignored, the counters reflect one resolution only, and both slots are invalid afterwards.
REQ-037 Stall=1 asserted with a branch in EX -> no resolution until Stall=0; Stall=1 during RECOVER -> Flush still 1 for one cycle.
REQ-038 rst asserted during RECOVER -> Flush=0 the next cycle, counters 0; Mispred_Count preloaded to all-ones via repeated mispredicts stays saturated.
